// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: walks start/data/parity/stop, deserialises LSB-first, flags errors.
// Optional macro RX_START_GLITCH_EN: a start bit sampled high at its end is treated as a glitch.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            edge_cnt,
    input  logic [2:0]            bit_cnt,
    input  logic                  bit_done,
    input  logic                  sampled_bit,
    output logic                  edge_count_enable,
    output logic                  bit_count_enable,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   shift_r, shift_s;
    logic                    acc_r, acc_s;
    logic                    par_err_s, stp_err_s, valid_s;
    logic [DATA_WIDTH-1:0]   p_data_s;

    // Bit timing comes entirely from bit_done, so the edge count itself is not consumed here.
    logic unused_edge_cnt_s;
    assign unused_edge_cnt_s = ^edge_cnt;

    // Mismatch between received parity bit and accumulated data parity, adjusted for odd/even.
    function automatic logic par_check(input logic acc, input logic par_bit, input logic typ);
        return acc ^ par_bit ^ typ;
    endfunction

    // Next-state and datapath update decode.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        acc_s     = acc_r;
        par_err_s = par_err;
        stp_err_s = stp_err;
        p_data_s  = P_DATA;
        valid_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                shift_s = '0;
                acc_s   = 1'b0;
                if (!RX_IN) begin
                    state_s   = ST_START;
                    par_err_s = 1'b0;
                    stp_err_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done) begin
`ifdef RX_START_GLITCH_EN
                    if (sampled_bit) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
`else
                    state_s = ST_DATA;
`endif
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_s = {sampled_bit, shift_r[DATA_WIDTH-1:1]};
                    acc_s   = acc_r ^ sampled_bit;
                    if (bit_cnt == 3'(DATA_WIDTH - 1)) begin
                        state_s = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_err_s = par_check(acc_r, sampled_bit, PAR_TYP);
                    state_s   = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    stp_err_s = ~sampled_bit;
                    // A frame is only delivered when both the stop and parity checks are clean.
                    if (sampled_bit && !par_err) begin
                        p_data_s = shift_r;
                        valid_s  = 1'b1;
                    end else begin
                        p_data_s = P_DATA;
                    end
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; enables are decoded from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r           <= ST_IDLE;
            shift_r           <= '0;
            acc_r             <= 1'b0;
            P_DATA            <= '0;
            data_valid        <= 1'b0;
            par_err           <= 1'b0;
            stp_err           <= 1'b0;
            edge_count_enable <= 1'b0;
            dat_samp_en       <= 1'b0;
            bit_count_enable  <= 1'b0;
        end else begin
            state_r           <= state_s;
            shift_r           <= shift_s;
            acc_r             <= acc_s;
            P_DATA            <= p_data_s;
            data_valid        <= valid_s;
            par_err           <= par_err_s;
            stp_err           <= stp_err_s;
            edge_count_enable <= (state_s != ST_IDLE);
            dat_samp_en       <= (state_s != ST_IDLE);
            bit_count_enable  <= (state_s == ST_DATA);
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; a small edge/bit counter and an ideal sampler drive the DUT.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [4:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic       bit_done;
    logic       sampled_bit;
    logic       edge_count_enable, bit_count_enable, dat_samp_en;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err;

    int prescale = 8;
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_done(bit_done), .sampled_bit(sampled_bit),
        .edge_count_enable(edge_count_enable), .bit_count_enable(bit_count_enable),
        .dat_samp_en(dat_samp_en), .P_DATA(p_data), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    // Clean line: the majority vote always equals the line level.
    assign sampled_bit = rx_in;
    assign bit_done = edge_count_enable && (edge_cnt == 5'(prescale - 1));

    // Edge/bit counter environment model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 3'd0;
        end else if (edge_count_enable) begin
            edge_cnt <= bit_done ? 5'd0 : edge_cnt + 5'd1;
            if (bit_count_enable && bit_done) bit_cnt <= bit_cnt + 3'd1;
        end else begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 3'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame; returns after the stop-bit edge (+1) with the line high again.
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                              output int early_valid, output logic [1:0] flags_e0);
        logic [10:0] bits;
        int nb;
        nb = par_en ? 11 : 10;
        bits = par_en ? {stop_bit, par_bit, data, 1'b0} : {1'b1, stop_bit, data, 1'b0};
        early_valid = 0;
        @(negedge clk);
        rx_in = 1'b0;
        @(posedge clk);
        #1;
        flags_e0 = {par_err, stp_err};
        for (int k = 0; k < nb; k++) begin
            rx_in = bits[k];
            for (int c = 0; c < prescale; c++) begin
                @(posedge clk);
                #1;
                if (!(k == nb - 1 && c == prescale - 1) && data_valid) early_valid++;
            end
        end
        rx_in = 1'b1;
    endtask

    initial begin
        int early;
        logic [1:0] fl;
        int dv_seen;

        #3;
        check("rst_ece", 32'(edge_count_enable), 32'h0);
        check("rst_bce", 32'(bit_count_enable), 32'h0);
        check("rst_dse", 32'(dat_samp_en), 32'h0);
        check("rst_pdata", 32'(p_data), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_flags", 32'({par_err, stp_err}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Prescale 8, even parity, 0xA5 (parity bit 0): valid exactly 88 edges after E0.
        prescale = 8; par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, early, fl);
        check("a5_early", 32'(early), 32'h0);
        check("a5_dv", 32'(data_valid), 32'h1);
        check("a5_pdata", 32'(p_data), 32'hA5);
        check("a5_flags", 32'({par_err, stp_err}), 32'h0);
        @(posedge clk); #1;
        check("a5_dv_pulse", 32'(data_valid), 32'h0);
        check("a5_idle", 32'(edge_count_enable), 32'h0);
        repeat (2) @(posedge clk);

        // Prescale 16, no parity, 0x3C.
        prescale = 16; par_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, early, fl);
        check("3c_early", 32'(early), 32'h0);
        check("3c_dv", 32'(data_valid), 32'h1);
        check("3c_pdata", 32'(p_data), 32'h3C);
        @(posedge clk); #1;
        check("3c_dv_pulse", 32'(data_valid), 32'h0);
        repeat (2) @(posedge clk);

        // Odd parity: 0x01 with parity bit 0 is correct.
        prescale = 8; par_en = 1'b1; par_typ = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1, early, fl);
        check("odd_ok_dv", 32'(data_valid), 32'h1);
        check("odd_ok_pdata", 32'(p_data), 32'h01);
        check("odd_ok_par", 32'(par_err), 32'h0);
        repeat (2) @(posedge clk);

        // Odd parity: 0x02 with parity bit 1 is a parity error.
        send_frame(8'h02, 1'b1, 1'b1, early, fl);
        check("par_early", 32'(early), 32'h0);
        check("par_dv", 32'(data_valid), 32'h0);
        check("par_err", 32'(par_err), 32'h1);
        check("par_stp", 32'(stp_err), 32'h0);
        check("par_pdata", 32'(p_data), 32'h01);
        repeat (2) @(posedge clk);

        // 0x55 with stop bit 0.
        par_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, early, fl);
        check("stp_early", 32'(early), 32'h0);
        check("stp_dv", 32'(data_valid), 32'h0);
        check("stp_err", 32'(stp_err), 32'h1);
        check("stp_par", 32'(par_err), 32'h0);
        check("stp_pdata", 32'(p_data), 32'h01);
        repeat (5) @(posedge clk); #1;
        check("stp_persist", 32'(stp_err), 32'h1);

        // Flags clear on the next start; good 0x0F at prescale 32.
        prescale = 32;
        send_frame(8'h0F, 1'b0, 1'b1, early, fl);
        check("0f_flags_e0", 32'(fl), 32'h0);
        check("0f_dv", 32'(data_valid), 32'h1);
        check("0f_pdata", 32'(p_data), 32'h0F);
        check("0f_early", 32'(early), 32'h0);
        repeat (2) @(posedge clk);

        // Short low pulse on an idle line.
        prescale = 8; par_en = 1'b0;
        dv_seen = 0;
        @(negedge clk);
        rx_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (prescale - 2) @(posedge clk);
        #1;
        check("glitch_in_start", 32'(edge_count_enable), 32'h1);
`ifdef RX_START_GLITCH_EN
        @(posedge clk); #1;
        check("glitch_idle", 32'(edge_count_enable), 32'h0);
        for (int i = 0; i < 10 * prescale; i++) begin
            @(posedge clk); #1;
            if (data_valid) dv_seen++;
        end
        check("glitch_no_dv", 32'(dv_seen), 32'h0);
        check("glitch_flags", 32'({par_err, stp_err}), 32'h0);
        check("glitch_pdata", 32'(p_data), 32'h0F);
`else
        // Without the glitch check an all-ones garbage frame is accepted.
        for (int i = 0; i < 9 * prescale + 1; i++) begin
            @(posedge clk); #1;
            if (i < 9 * prescale && data_valid) dv_seen++;
        end
        check("false_start_early", 32'(dv_seen), 32'h0);
        check("false_start_dv", 32'(data_valid), 32'h1);
        check("false_start_pdata", 32'(p_data), 32'hFF);
`endif
        repeat (2) @(posedge clk);
        send_frame(8'h81, 1'b0, 1'b1, early, fl);
        check("81_dv", 32'(data_valid), 32'h1);
        check("81_pdata", 32'(p_data), 32'h81);
        repeat (2) @(posedge clk);

        // Asynchronous reset during data bit 4 of 0xFF.
        @(negedge clk);
        rx_in = 1'b0;
        @(posedge clk);
        repeat (prescale) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (4 * prescale + 3) @(posedge clk);
        #1;
        check("mid_busy", 32'(bit_count_enable), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ece", 32'(edge_count_enable), 32'h0);
        check("arst_bce", 32'(bit_count_enable), 32'h0);
        check("arst_dse", 32'(dat_samp_en), 32'h0);
        check("arst_outs", 32'({p_data, data_valid, par_err, stp_err}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        send_frame(8'h12, 1'b0, 1'b1, early, fl);
        check("12_early", 32'(early), 32'h0);
        check("12_dv", 32'(data_valid), 32'h1);
        check("12_pdata", 32'(p_data), 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
